// File: rtl/led_pkg.sv
// Shared types and defaults for the LED matrix serial frame receiver.
package led_pkg;

  localparam int LED_NLEDS = 64;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } ledrx_state_t;

endpackage

// File: rtl/edge_sync.sv
// Brings one asynchronous pin into the clk domain through a flop chain and
// produces a single-cycle rise pulse from the synchronized level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/led_frame_receiver.sv
// Serial LED frame receiver: shifts din on dclk rises, commits on strobe rises.
// Optional LEDRX_LENGTH_CHECK_EN rejects short/overrun frames and adds frame_err.
module led_frame_receiver
  import led_pkg::*;
#(
  parameter int NLEDS       = LED_NLEDS,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             dclk,
  input  logic             strobe,
  output logic [NLEDS-1:0] frame_data,
  output logic             frame_update,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
`ifdef LEDRX_LENGTH_CHECK_EN
  ,
  output logic             frame_err
`endif
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NLEDS);

  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   din_s;
  logic                   dclk_rise;
  logic                   strobe_rise;
  logic [NLEDS-1:0]       shift_reg;
  ledrx_state_t           state_q, state_d;
  logic                   commit;

  // din goes through the same depth as dclk so the sampled bit lines up with its rise.
  always_ff @(posedge clk) begin
    if (reset) din_sync_q <= '0;
    else       din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
  end
  assign din_s = din_sync_q[SYNC_STAGES-1];

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dclk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (dclk),
    .rise  (dclk_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (strobe),
    .rise  (strobe_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: defaults first so no path through the block leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (strobe_rise) begin
      state_d = COMMIT;
    end else begin
      unique case (state_q)
        IDLE:    if (dclk_rise) state_d = SHIFT;
        SHIFT:   state_d = SHIFT;
        COMMIT:  state_d = dclk_rise ? SHIFT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign commit = (state_q == COMMIT);

  // A shift in the commit cycle belongs to the next frame; the committed value is pre-shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg    <= '0;
      frame_data   <= '0;
      frame_update <= 1'b0;
      bit_count    <= '0;
      overrun      <= 1'b0;
`ifdef LEDRX_LENGTH_CHECK_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      frame_update <= 1'b0;
`ifdef LEDRX_LENGTH_CHECK_EN
      frame_err    <= 1'b0;
`endif
      if (dclk_rise) shift_reg <= {shift_reg[NLEDS-2:0], din_s};

      if (commit) begin
        bit_count <= dclk_rise ? CNT_W'(1) : '0;
        overrun   <= 1'b0;
`ifdef LEDRX_LENGTH_CHECK_EN
        if (bit_count == FULL && !overrun) begin
          frame_data   <= shift_reg;
          frame_update <= 1'b1;
        end else begin
          frame_err    <= 1'b1;
        end
`else
        frame_data   <= shift_reg;
        frame_update <= 1'b1;
`endif
      end else if (dclk_rise) begin
        if (bit_count == FULL) overrun <= 1'b1;
        else                   bit_count <= bit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_frame_receiver.sv
// Directed self-checking bench for led_frame_receiver with a frame scoreboard.
// Build with +define+LEDRX_LENGTH_CHECK_EN to exercise the length-check variant.
module tb_led_frame_receiver;

  localparam int NLEDS = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             din;
  logic             dclk;
  logic             strobe;
  logic [NLEDS-1:0] frame_data;
  logic             frame_update;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;
`ifdef LEDRX_LENGTH_CHECK_EN
  logic             frame_err;
`endif

  led_frame_receiver #(.NLEDS(NLEDS), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .dclk         (dclk),
    .strobe       (strobe),
    .frame_data   (frame_data),
    .frame_update (frame_update),
    .bit_count    (bit_count),
    .overrun      (overrun)
`ifdef LEDRX_LENGTH_CHECK_EN
    ,
    .frame_err    (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_err = 0;
  int               n_upd = 0;
  int               n_ferr = 0;
  logic [NLEDS-1:0] sb[$];
  logic [NLEDS-1:0] exp_frame = '0;
  logic [NLEDS-1:0] exp_shift;
  int               exp_count;
  bit               exp_ovr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each update, otherwise frame_data must hold.
  always @(negedge clk) begin
    if (reset) begin
      exp_frame = '0;
    end else if (frame_update) begin
      n_upd++;
      check("update_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_frame = sb.pop_front();
        check("frame_data", frame_data, exp_frame);
      end
    end else begin
      check("frame_stable", frame_data, exp_frame);
    end
`ifdef LEDRX_LENGTH_CHECK_EN
    if (!reset && frame_err) n_ferr++;
`endif
  end

  task automatic model_shift(input logic b);
    exp_shift = {exp_shift[NLEDS-2:0], b};
    if (exp_count == NLEDS) exp_ovr = 1'b1;
    else                    exp_count++;
  endtask

  task automatic model_reset();
    exp_shift = '0;
    exp_count = 0;
    exp_ovr   = 1'b0;
    sb.delete();
  endtask

  task automatic send_bit(input logic b);
    din = b;
    step(4);
    dclk = 1'b1;
    model_shift(b);
    step(4);
    dclk = 1'b0;
  endtask

  task automatic send_word(input logic [NLEDS-1:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // Strobe of width w; with_bit raises dclk (data b) in the same clk as strobe.
  task automatic strobe_pulse(input int w, input bit with_bit, input logic b);
    int  upd0, ferr0;
    bit  valid;
    upd0  = n_upd;
    ferr0 = n_ferr;
    if (with_bit) begin
      din = b;
      step(4);
      dclk = 1'b1;
      model_shift(b);
    end
`ifdef LEDRX_LENGTH_CHECK_EN
    valid = (exp_count == NLEDS) && !exp_ovr;
`else
    valid = 1'b1;
`endif
    if (valid) sb.push_back(exp_shift);
    strobe = 1'b1;
    step(w);
    strobe = 1'b0;
    if (with_bit) begin
      step(4 - w);
      dclk = 1'b0;
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    check("commit_timeout", 64'(sb.size()), 64'd0);
    step(4);
    exp_count = 0;
    exp_ovr   = 1'b0;
    check("update_pulses", 64'(n_upd - upd0), valid ? 64'd1 : 64'd0);
`ifdef LEDRX_LENGTH_CHECK_EN
    check("frame_err_pulses", 64'(n_ferr - ferr0), valid ? 64'd0 : 64'd1);
`else
    check("frame_err_pulses", 64'(n_ferr - ferr0), 64'd0);
`endif
    check("bit_count_after_commit", 64'(bit_count), 64'd0);
    check("overrun_after_commit", 64'(overrun), 64'd0);
  endtask

  initial begin
    logic [NLEDS-1:0] word;
    din = 1'b0; dclk = 1'b0; strobe = 1'b0;
    model_reset();

    // 1: reset state
    reset = 1'b1;
    step(3);
    check("rst_frame_data", frame_data, 64'd0);
    check("rst_bit_count", 64'(bit_count), 64'd0);
    check("rst_frame_update", 64'(frame_update), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b0;
    step(2);

    // 6: wide strobe with no data re-commits the zero shift register once
    strobe_pulse(2, 1'b0, 1'b0);

    // 2: full frame MSB-first
    word = 64'hDEADBEEF_0123_4567;
    send_word(word, NLEDS);
    check("full_bit_count", 64'(bit_count), 64'd64);
    check("full_overrun", 64'(overrun), 64'd0);
    strobe_pulse(1, 1'b0, 1'b0);

    // 3: 70 bits, last 64 win and overrun is flagged
    word = {$urandom, $urandom};
    send_word(word, NLEDS);
    word = 64'h2B;
    send_word(word, 6);
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_bit_count", 64'(bit_count), 64'd64);
    strobe_pulse(1, 1'b0, 1'b0);

    // 4: 63 bits, then 64th dclk rise coincident with strobe
    word = 64'hA5C3_0F1E_7788_9911;
    send_word(word, NLEDS - 1);
    check("b63_bit_count", 64'(bit_count), 64'd63);
    strobe_pulse(1, 1'b1, 1'b1);

    // 5: partial frame discarded by reset
    word = 64'h3FFF_FFFF;
    send_word(word, 30);
    reset = 1'b1;
    model_reset();
    step(1);
    check("rst5_frame_data", frame_data, 64'd0);
    check("rst5_bit_count", 64'(bit_count), 64'd0);
    reset = 1'b0;
    step(2);
    word = 64'h0123_4567_89AB_CDEF;
    send_word(word, NLEDS);
    strobe_pulse(1, 1'b0, 1'b0);
    check("new_frame_only", frame_data, word);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
